// File: rtl/alu_issue_arb.sv
// alu_issue_arb: round-robin issue arbiter in front of one integer ALU.
// Eligible requesters are granted one per cycle into a 2-entry FIFO skid buffer
// whose head drives the ALU execute port (1-cycle latency, no bypass).
// Optional macro ALU_ARB_BR_LOCK_EN: a requester that issues a branch is locked
// out until its branch resolves (br_done_valid/br_done_idx).
module alu_issue_arb #(
   parameter  int NUM_REQS = 4,
   parameter  int DATAW    = 64,
   localparam int REQ_BITS = $clog2(NUM_REQS)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQS-1:0]       req_valid,
   input  logic [NUM_REQS*DATAW-1:0] req_data,
   input  logic [NUM_REQS-1:0]       req_is_br,
   output logic [NUM_REQS-1:0]       req_ready,
   output logic                      out_valid,
   output logic [DATAW-1:0]          out_data,
   output logic [REQ_BITS-1:0]       out_idx,
   input  logic                      out_ready,
   input  logic                      br_done_valid,
   input  logic [REQ_BITS-1:0]       br_done_idx
);

   localparam logic [REQ_BITS:0]   NREQ_W   = (REQ_BITS+1)'(NUM_REQS);
   localparam logic [REQ_BITS-1:0] LAST_IDX = REQ_BITS'(NUM_REQS-1);

   logic [REQ_BITS-1:0] rr_ptr;
   logic [NUM_REQS-1:0] lock_q;
   logic [1:0]          count;
   logic                wr_ptr;
   logic                rd_ptr;
   logic [DATAW-1:0]    buf_data [2];
   logic [REQ_BITS-1:0] buf_idx  [2];

   logic                full;
   logic                push;
   logic                pop;
   logic [NUM_REQS-1:0] elig;
   logic                gnt_vld;
   logic [REQ_BITS-1:0] gnt_idx;

   assign full = (count == 2'd2);
   assign elig = req_valid & ~lock_q & {NUM_REQS{~full}};

   // round-robin search starting at rr_ptr, wrapping past NUM_REQS-1
   always_comb begin
      logic [REQ_BITS:0] pos;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      pos     = '0;
      for (int i = 0; i < NUM_REQS; i++) begin
         pos = {1'b0, rr_ptr} + (REQ_BITS+1)'(i);
         if (pos >= NREQ_W) pos = pos - NREQ_W;
         if (!gnt_vld && elig[pos[REQ_BITS-1:0]]) begin
            gnt_vld = 1'b1;
            gnt_idx = pos[REQ_BITS-1:0];
         end
      end
   end

   // one-hot accept; held low while reset is asserted
   always_comb begin
      req_ready = '0;
      if (gnt_vld && reset) req_ready[gnt_idx] = 1'b1;
   end

   assign push      = gnt_vld & reset;
   assign out_valid = (count != 2'd0);
   assign pop       = out_valid & out_ready;
   assign out_data  = buf_data[rd_ptr];
   assign out_idx   = buf_idx[rd_ptr];

   // FIFO pointers, occupancy and round-robin pointer
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count  <= 2'd0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         rr_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= ~wr_ptr;
            rr_ptr <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: ;
         endcase
      end
   end

   // payload storage; validity is tracked by count, so no reset needed
   always_ff @(posedge clk) begin
      if (push) begin
         buf_data[wr_ptr] <= req_data[gnt_idx*DATAW +: DATAW];
         buf_idx[wr_ptr]  <= gnt_idx;
      end
   end

`ifdef ALU_ARB_BR_LOCK_EN
   logic [NUM_REQS-1:0] lock_set;
   logic [NUM_REQS-1:0] lock_clr;

   // lock on an accepted branch, unlock on its resolution
   always_comb begin
      lock_set = '0;
      lock_clr = '0;
      if (push) lock_set[gnt_idx] = req_is_br[gnt_idx];
      if (br_done_valid) begin
         for (int i = 0; i < NUM_REQS; i++) begin
            if (br_done_idx == REQ_BITS'(i)) lock_clr[i] = 1'b1;
         end
      end
   end

   // set applied after clear so a same-cycle set wins
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) lock_q <= '0;
      else        lock_q <= (lock_q & ~lock_clr) | lock_set;
   end
`else
   logic unused_br;
   assign lock_q    = '0;
   assign unused_br = ^{req_is_br, br_done_valid, br_done_idx};
`endif

endmodule
